// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and register addresses for the UART transmit FIFO.
// Register addresses are taken from the shared uart_defines.vh.
`include "uart_defines.vh"

package uart_tx_fifo_pkg;

  localparam int unsigned REG_TR = `UART_REG_TR;
  localparam int unsigned REG_LC = `UART_REG_LC;
  localparam int unsigned REG_LS = `UART_REG_LS;

  // Encoded as {push, pop} so the accepted operations map directly onto it.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_defines.vh
// Register map and thresholds shared by the UART blocks.
`ifndef UART_DEFINES_VH
`define UART_DEFINES_VH

`define UART_REG_TR 0
`define UART_REG_LC 3
`define UART_REG_LS 5

`ifndef UART_TX_LOWWATER
`define UART_TX_LOWWATER 4
`endif

`endif

// File: rtl/uart_fifo_mem.sv
// Byte storage for the TX FIFO: one synchronous write port and one
// asynchronous read port so the head entry is always visible.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with show-ahead head, registered level/empty and a sticky
// overrun flag. Optional low-water output: define UART_TX_FIFO_LOWWATER_EN.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic                     we,
  input  logic [7:0]               w_data_in,
  input  logic                     re,
  input  logic                     fifo_clr,
  input  logic                     tx_pop,
  output logic [7:0]               tx_data,
  output logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic                     tf_overrun
`ifdef UART_TX_FIFO_LOWWATER_EN
  ,
  output logic                     tx_lowwater
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] level_nxt;

  logic     tr_sel;
  logic     ls_sel;
  logic     full;
  logic     push_req;
  logic     pop_ok;
  logic     push_ok;
  logic     ovr_set;
  logic     ovr_clr;
  fifo_op_e op;

  assign tr_sel = (addr_in == ADDRESS_WIDTH'(REG_TR));
  assign ls_sel = (addr_in == ADDRESS_WIDTH'(REG_LS));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign push_req = we && tr_sel;
  assign pop_ok   = tx_pop && !tx_empty && !fifo_clr;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_ok  = push_req && !fifo_clr && (!full || pop_ok);
  assign ovr_set  = push_req && !fifo_clr && full && !pop_ok;
  assign ovr_clr  = (re && ls_sel) || fifo_clr;

  assign op = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (fifo_clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      case (op)
        FIFO_PUSH: wr_ptr_nxt = wr_ptr + PW'(1);
        FIFO_POP:  rd_ptr_nxt = rd_ptr + PW'(1);
        FIFO_BOTH: begin
          wr_ptr_nxt = wr_ptr + PW'(1);
          rd_ptr_nxt = rd_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign level_nxt = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_empty   <= 1'b1;
      tx_level   <= '0;
      tf_overrun <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      tx_empty <= (level_nxt == '0);
      tx_level <= level_nxt;
      if (ovr_set) begin
        tf_overrun <= 1'b1;
      end else if (ovr_clr) begin
        tf_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_LOWWATER_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_lowwater <= 1'b1;
    end else begin
      tx_lowwater <= (level_nxt <= PW'(`UART_TX_LOWWATER));
    end
  end
`endif

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_mem (
    .clk     (wb_clk_i),
    .wr_en   (push_ok && !wb_rst_i),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (w_data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (tx_data)
  );

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5: width of the register address bus.
REQ-002 SHALL have parameter DEPTH, default 16: number of FIFO entries, power of two, 4..64.
REQ-003 SHALL have port wb_clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port addr_in, input, ADDRESS_WIDTH: register address from the AXI4-Lite slave.
REQ-006 SHALL have port we, input, 1: single-cycle register write strobe.
REQ-007 SHALL have port w_data_in, input, 8: write byte.
REQ-008 SHALL have port re, input, 1: register read strobe.
REQ-009 SHALL have port fifo_clr, input, 1: TX FIFO flush (FCR clear bit).
REQ-010 SHALL have port tx_pop, input, 1: transmitter consumes the head entry.
REQ-011 SHALL have port tx_data, output, 8: head entry, show-ahead.
REQ-012 SHALL have port tx_empty, output, 1: FIFO holds no entries.
REQ-013 SHALL have port tx_level, output, $clog2(DEPTH)+1: current occupancy.
REQ-014 SHALL have port tf_overrun, output, 1: sticky overrun flag returned to the AXI4-Lite slave.

Function
REQ-015 SHALL push w_data_in when we=1 and addr_in==UART_REG_TR; all other writes are ignored.
REQ-016 SHALL pop when tx_pop=1 and tx_empty=0; tx_pop while empty has no effect.
REQ-017 SHALL drive tx_data combinationally from mem[rd_ptr]; value is don't-care while tx_empty=1.
REQ-018 SHALL use read and write pointers $clog2(DEPTH)+1 bits wide; full when the MSBs differ and the low bits are equal; empty when the pointers are equal; the pointers wrap naturally.
REQ-019 SHALL update tx_level and tx_empty on the clock edge after the push or pop (registered flags, no zero-cycle fall-through).
REQ-020 SHALL accept both operations on a simultaneous push and pop when full: level stays DEPTH, no overrun.
REQ-021 SHALL perform only the push on a simultaneous push and pop when empty: level becomes 1.
REQ-022 SHALL drop the byte on a push while full (no pointer or memory change) and set tf_overrun on the next edge.
REQ-023 SHALL hold tf_overrun until the first clock edge where re=1 and addr_in==UART_REG_LS, or fifo_clr=1.
REQ-024 SHALL give the set of tf_overrun priority over the clear when both occur on the same edge.
REQ-025 SHALL make tf_overrun visible by the slave's write-response cycle, i.e. one cycle after the we pulse.
REQ-026 SHALL, on fifo_clr, zero both pointers on the next edge and ignore any same-cycle push or pop; memory contents are left unchanged.

Reset
REQ-027 SHALL, on wb_rst_i=1 at a clock edge, set rd_ptr=0, wr_ptr=0, tx_empty=1, tx_level=0, tf_overrun=0; memory is not reset.
REQ-028 SHALL treat reset mid-operation (pending push or pop) as taking priority over all other inputs.

Configuration
REQ-029 SHALL, with macro UART_TX_FIFO_LOWWATER_EN defined, add output tx_lowwater (1 bit), registered, =1 when the next-state level is <= `UART_TX_LOWWATER, reset value 1.
REQ-030 SHALL, without UART_TX_FIFO_LOWWATER_EN, have no tx_lowwater port and no associated logic.

Structure
REQ-031 SHALL take UART_REG_TR, UART_REG_LS and UART_TX_LOWWATER (default 4) from the shared uart_defines.vh; no local address constants.
REQ-032 SHALL place storage in sub-module uart_fifo_mem: DEPTH x 8, one synchronous write port, one asynchronous read port.

Verification
REQ-033 Fill: 16 writes to UART_REG_TR of 0x00..0x0F -> tx_level=16, tx_empty=0, tf_overrun=0, tx_data=0x00.
REQ-034 Overrun: 17th write of 0xAA while full -> byte dropped, tf_overrun=1 one cycle later; re at UART_REG_LS -> tf_overrun=0 the next cycle.
REQ-035 Drain and wrap: pop 16 entries -> bytes come out 0x00..0x0F in order, tx_empty=1; then 20 push/pop cycles across the wrap show no data loss.
REQ-036 Simultaneous events: push 0x55 + pop when full -> level stays 16, no overrun; push + pop when empty -> level=1, tx_data=0x55.
REQ-037 Flush and reset: fifo_clr with level=7 plus same-cycle push -> level=0, tf_overrun=0; wb_rst_i mid-burst -> all outputs at reset values next cycle.
REQ-038 Non-TR write: we to UART_REG_LC with data 0x03 -> tx_level unchanged.
